// File: rtl/key_cond_pkg.sv
// Shared key indices, masks and the repeat-phase type for the key conditioner.
package key_cond_pkg;

   localparam int KEY_INC = 1;
   localparam int KEY_DEC = 2;
   localparam int KEY_OK  = 3;
   localparam int KEY_RST = 4;

   localparam logic [4:1] KEY_MASKABLE   = 4'b0111;
   localparam logic [4:1] KEY_REPEATABLE = 4'b0011;

   typedef enum logic {
      REP_DELAY,
      REP_PERIOD
   } rep_phase_e;

   function automatic int max2(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/key_cond_debounce.sv
// One key channel: two-flop synchroniser feeding a DB_CYCLES-sample debouncer.
// o_fall flags the cycle on which the debounced level is about to become "pressed".
module key_debounce #(
   parameter int DB_CYCLES = 500000
) (
   input  logic clk,
   input  logic rst_n,
   input  logic i_key_n_raw,
   output logic o_stable,
   output logic o_fall
);

   localparam int              CW       = $clog2(DB_CYCLES);
   localparam logic [CW-1:0]   CNT_LAST = CW'(DB_CYCLES - 1);

   logic          r_sync1;
   logic          r_sync2;
   logic          r_stable;
   logic [CW-1:0] r_cnt;
   logic          w_differs;
   logic          w_accept;

   assign w_differs = (r_sync2 != r_stable);
   assign w_accept  = w_differs && (r_cnt == CNT_LAST);

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         // NOTE: released (1) is the reset level, so a key held through reset reads as a fresh press.
         r_sync1  <= 1'b1;
         r_sync2  <= 1'b1;
         r_stable <= 1'b1;
         r_cnt    <= '0;
      end else begin
         r_sync1 <= i_key_n_raw;
         r_sync2 <= r_sync1;
         if (!w_differs) begin
            r_cnt <= '0;
         end else if (w_accept) begin
            r_stable <= ~r_stable;
            r_cnt    <= '0;
         end else begin
            r_cnt <= r_cnt + CW'(1);
         end
      end
   end

   assign o_stable = r_stable;
   assign o_fall   = w_accept & r_stable;

endmodule

// File: rtl/key_cond.sv
// Four-key conditioner: debounce, press-edge pulses, keys_ena masking of keys 1-3.
// Optional auto-repeat on keys 1-2 is built when KEY_COND_REPEAT_EN is defined.
module key_cond
   import key_cond_pkg::*;
#(
   parameter int DB_CYCLES     = 500000,
   parameter int REPEAT_DELAY  = 25000000,
   parameter int REPEAT_PERIOD = 5000000
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [4:1] key_n_raw,
   input  logic       keys_ena,
   output logic [4:1] key,
   output logic [4:1] key_lvl
);

   logic [4:1] w_stable;
   logic [4:1] w_fall;
   logic [4:1] w_ena_mask;
   logic [4:1] w_press;
   logic [4:1] w_rep;
   logic [4:1] r_key;

   genvar g;
   for (g = KEY_INC; g <= KEY_RST; g++) begin : g_chan
      key_debounce #(
         .DB_CYCLES(DB_CYCLES)
      ) u_db (
         .clk        (clk),
         .rst_n      (rst_n),
         .i_key_n_raw(key_n_raw[g]),
         .o_stable   (w_stable[g]),
         .o_fall     (w_fall[g])
      );
   end

   assign w_ena_mask = ~KEY_MASKABLE | {4{keys_ena}};
   assign w_press    = w_fall & w_ena_mask;
   assign key_lvl    = ~w_stable;

`ifdef KEY_COND_REPEAT_EN
   localparam int            RW          = $clog2(max2(REPEAT_DELAY, REPEAT_PERIOD) + 1);
   localparam logic [RW-1:0] DELAY_LAST  = RW'(REPEAT_DELAY - 1);
   localparam logic [RW-1:0] PERIOD_LAST = RW'(REPEAT_PERIOD - 1);

   for (g = KEY_INC; g <= KEY_RST; g++) begin : g_rep
      if (KEY_REPEATABLE[g]) begin : g_on
         logic          r_act;
         rep_phase_e    r_phase;
         logic [RW-1:0] r_cnt;
         logic          w_act_nxt;
         rep_phase_e    w_phase_nxt;
         logic [RW-1:0] w_cnt_nxt;
         logic          w_hold;
         logic [RW-1:0] w_last;

         assign w_hold   = key_lvl[g] & keys_ena;
         assign w_last   = (r_phase == REP_DELAY) ? DELAY_LAST : PERIOD_LAST;
         assign w_rep[g] = r_act & w_hold & (r_cnt == w_last);

         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               r_act   <= 1'b0;
               r_phase <= REP_DELAY;
               r_cnt   <= '0;
            end else begin
               r_act   <= w_act_nxt;
               r_phase <= w_phase_nxt;
               r_cnt   <= w_cnt_nxt;
            end
         end

         // Only a real press pulse arms repeats; re-enabling while held leaves r_act clear.
         always_comb begin
            // NOTE: hold-current defaults first, so no path through this block infers a latch.
            w_act_nxt   = r_act;
            w_phase_nxt = r_phase;
            w_cnt_nxt   = r_cnt;
            if (w_press[g]) begin
               w_act_nxt   = 1'b1;
               w_phase_nxt = REP_DELAY;
               w_cnt_nxt   = '0;
            end else if (!w_hold) begin
               w_act_nxt   = 1'b0;
               w_phase_nxt = REP_DELAY;
               w_cnt_nxt   = '0;
            end else if (r_act) begin
               if (w_rep[g]) begin
                  w_phase_nxt = REP_PERIOD;
                  w_cnt_nxt   = '0;
               end else begin
                  w_cnt_nxt = r_cnt + RW'(1);
               end
            end
         end
      end else begin : g_off
         assign w_rep[g] = 1'b0;
      end
   end
`else
   // Repeat parameters remain in the interface for drop-in builds; nothing consumes them here.
   localparam bit REPEAT_CFG_OK = (REPEAT_DELAY > 0) && (REPEAT_PERIOD > 0);
   assign w_rep = {4{1'b0 & REPEAT_CFG_OK}};
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_key <= '0;
      end else begin
         r_key <= w_press | w_rep;
      end
   end

   assign key = r_key;

endmodule

// File: tb/tb_key_cond.sv
// Self-checking bench for key_cond: directed scenarios plus random stimulus against
// a sample-window behavioural model compared on every falling clock edge.
module tb_key_cond;

   localparam int DB = 4;
   localparam int RD = 20;
   localparam int RP = 6;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [4:1] key_n_raw;
   logic       keys_ena;
   logic [4:1] key;
   logic [4:1] key_lvl;

   int n_checks = 0;
   int n_fail   = 0;
   int pulse_cnt [1:4];
   int p, p1, p3, rep_cnt;
   bit found, seen20, seen26;

   always #5 clk = ~clk;

   key_cond #(
      .DB_CYCLES    (DB),
      .REPEAT_DELAY (RD),
      .REPEAT_PERIOD(RP)
   ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .key_n_raw(key_n_raw),
      .keys_ena (keys_ena),
      .key      (key),
      .key_lvl  (key_lvl)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
      end
   endtask

   // ---------------- behavioural model ----------------
   // Raw history per key; the synchronised sample at an edge is the raw value two edges
   // earlier, and the level flips once the last DB samples all disagree with it.
   bit         m_h [1:4][0:DB+1];
   bit         m_stable [1:4];
   bit         m_flip, m_pulse, m_rep;
   logic [4:1] exp_key, exp_lvl;
`ifdef KEY_COND_REPEAT_EN
   bit         m_act [1:4];
   int         m_n [1:4];
   bit         m_held;
`endif

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 1; i <= 4; i++) begin
            for (int j = 0; j <= DB + 1; j++) m_h[i][j] = 1'b1;
            m_stable[i] = 1'b1;
`ifdef KEY_COND_REPEAT_EN
            m_act[i] = 1'b0;
            m_n[i]   = 0;
`endif
         end
         exp_key = '0;
         exp_lvl = '0;
      end else begin
         for (int i = 1; i <= 4; i++) begin
            for (int j = DB + 1; j > 0; j--) m_h[i][j] = m_h[i][j-1];
            m_h[i][0] = key_n_raw[i];
            m_flip = 1'b1;
            for (int j = 2; j <= DB + 1; j++) if (m_h[i][j] == m_stable[i]) m_flip = 1'b0;
`ifdef KEY_COND_REPEAT_EN
            m_held = !m_stable[i];
`endif
            m_pulse = m_flip && m_stable[i] && (i == 4 || keys_ena);
            if (m_flip) m_stable[i] = !m_stable[i];
            m_rep = 1'b0;
`ifdef KEY_COND_REPEAT_EN
            if (i <= 2) begin
               if (m_pulse) begin
                  m_act[i] = 1'b1;
                  m_n[i]   = 0;
               end else if (!(m_held && keys_ena)) begin
                  m_act[i] = 1'b0;
               end else if (m_act[i]) begin
                  m_n[i]++;
                  m_rep = (m_n[i] == RD) || (m_n[i] > RD && ((m_n[i] - RD) % RP) == 0);
               end
            end
`endif
            exp_key[i] = m_pulse | m_rep;
            exp_lvl[i] = !m_stable[i];
         end
      end
   end

   always @(negedge clk) begin
      check("key", {28'd0, key}, {28'd0, exp_key});
      check("key_lvl", {28'd0, key_lvl}, {28'd0, exp_lvl});
   end

   initial for (int i = 1; i <= 4; i++) pulse_cnt[i] = 0;
   always @(negedge clk) for (int i = 1; i <= 4; i++) if (key[i] === 1'b1) pulse_cnt[i]++;

   task automatic edges(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: time limit reached");
      $fatal(1, "timeout");
   end

   // ---------------- stimulus ----------------
   initial begin
      rst_n     = 1'b0;
      key_n_raw = 4'hF;
      keys_ena  = 1'b1;
      edges(1);
      check("reset_key", {28'd0, key}, 32'd0);
      check("reset_lvl", {28'd0, key_lvl}, 32'd0);
      @(negedge clk); #2 rst_n = 1'b1;
      idle(5);

      // Clean press on key 3
      @(negedge clk); key_n_raw[3] = 1'b0;
      edges(5);
      check("clean_pre_pulse", key[3], 0);
      check("clean_pre_lvl", key_lvl[3], 0);
      edges(1);
      check("clean_pulse", key[3], 1);
      check("clean_lvl", key_lvl[3], 1);
      check("model_clean_pulse", exp_key[3], 1);
      edges(1);
      check("clean_width", key[3], 0);
      idle(24);
      @(negedge clk); key_n_raw[3] = 1'b1; p = pulse_cnt[3];
      edges(5);
      check("release_lvl_held", key_lvl[3], 1);
      edges(1);
      check("release_lvl", key_lvl[3], 0);
      edges(3);
      check("release_no_pulse", pulse_cnt[3] - p, 0);
      idle(5);

      // Bounce on key 1
      p = pulse_cnt[1];
      for (int i = 0; i < 20; i++) begin
         @(negedge clk); key_n_raw[1] = ((i / 2) % 2) != 0;
      end
      @(negedge clk); key_n_raw[1] = 1'b0;
      edges(5);
      check("bounce_quiet", pulse_cnt[1] - p, 0);
      edges(1);
      check("bounce_pulse", key[1], 1);
      edges(2);
      check("bounce_one_pulse", pulse_cnt[1] - p, 1);
      idle(3);
      @(negedge clk); key_n_raw[1] = 1'b1;
      idle(10);

      // Masking
      @(negedge clk); keys_ena = 1'b0; key_n_raw = 4'b0010;
      edges(6);
      check("mask_only_key4", {28'd0, key}, 32'h8);
      @(negedge clk); keys_ena = 1'b1; p1 = pulse_cnt[1]; p3 = pulse_cnt[3];
      idle(10);
      check("mask_reenable_k1", pulse_cnt[1] - p1, 0);
      check("mask_reenable_k3", pulse_cnt[3] - p3, 0);
      @(negedge clk); key_n_raw = 4'hF;
      idle(10);
      @(negedge clk); key_n_raw = 4'b1110;
      edges(6);
      check("mask_repress_k1", {28'd0, key}, 32'h1);
      idle(3);
      @(negedge clk); key_n_raw = 4'hF;
      idle(10);

      // Simultaneous press
      @(negedge clk); key_n_raw = 4'h0;
      edges(6);
      check("simul_all", {28'd0, key}, 32'hF);
      check("model_simul_all", {28'd0, exp_key}, 32'hF);
      edges(1);
      check("simul_clear", {28'd0, key}, 32'h0);
      idle(5);
      @(negedge clk); key_n_raw = 4'hF;
      idle(10);

      // Reset mid-debounce with keys held
      @(negedge clk); key_n_raw[4] = 1'b0;
      idle(10);
      check("pre_reset_lvl4", key_lvl[4], 1);
      @(negedge clk); key_n_raw[2] = 1'b0;
      edges(4);
      #1 rst_n = 1'b0;
      #1;
      check("reset_async_lvl", {28'd0, key_lvl}, 32'h0);
      check("reset_async_key", {28'd0, key}, 32'h0);
      @(negedge clk); #2 rst_n = 1'b1;
      edges(5);
      check("post_reset_quiet", {28'd0, key}, 32'h0);
      edges(1);
      check("post_reset_pulse", {28'd0, key}, 32'hA);
      idle(3);
      @(negedge clk); key_n_raw = 4'hF;
      idle(10);

      // Repeat on key 2, keys_ena dropped before P+30
      @(negedge clk); key_n_raw[2] = 1'b0;
      found = 1'b0;
      for (int c = 0; c < 20 && !found; c++) begin
         edges(1);
         if (key[2] === 1'b1) found = 1'b1;
      end
      check("rep_press_seen", found, 1);
      rep_cnt = 0; seen20 = 1'b0; seen26 = 1'b0;
      for (int k = 1; k <= 50; k++) begin
         @(negedge clk);
         if (k == 30) keys_ena = 1'b0;
         edges(1);
         if (key[2] === 1'b1) begin
            rep_cnt++;
            if (k == 20) seen20 = 1'b1;
            if (k == 26) seen26 = 1'b1;
         end
      end
`ifdef KEY_COND_REPEAT_EN
      check("rep_at_20", seen20, 1);
      check("rep_at_26", seen26, 1);
      check("rep_total", rep_cnt, 2);
`else
      check("rep_none_at_20", seen20, 0);
      check("rep_total", rep_cnt, 0);
`endif
      @(negedge clk); key_n_raw = 4'hF; keys_ena = 1'b1;
      idle(10);

      // Random stimulus
      for (int c = 0; c < 3000; c++) begin
         @(negedge clk);
         for (int i = 1; i <= 4; i++)
            if ($urandom_range(0, 99) < 5) key_n_raw[i] = ~key_n_raw[i];
         if ($urandom_range(0, 99) < 2) keys_ena = ~keys_ena;
      end
      @(negedge clk); key_n_raw = 4'hF; keys_ena = 1'b1;
      idle(20);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
